// File: rtl/uart_fifo_lvl.sv
// Show-ahead FIFO with registered level flags and an s_tick enable.
// Define UART_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module uart_fifo_lvl #(
    parameter int DATA_SIZE   = 10,
    parameter int SIZE_FIFO   = 16,
    parameter int AF_THRESH   = 14,
    parameter int AE_THRESH   = 2,
    localparam int ADDR_WIDTH = $clog2(SIZE_FIFO)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_tick,
    input  logic [DATA_SIZE-1:0]  w_data,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  err_clr,
    output logic [DATA_SIZE-1:0]  r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(SIZE_FIFO);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_SIZE-1:0]  mem [SIZE_FIFO];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;

    // A write into a full FIFO is allowed only when a read frees the head slot
    // in the same cycle; pointers wrap naturally because SIZE_FIFO is a power of two.
    always_comb begin
        wr_ok = s_tick & wr & (~full | (rd & ~empty));
        rd_ok = s_tick & rd & ~empty;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    assign r_data = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    // Flags are computed from the next count so they line up with count itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (s_tick) begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            count        <= count_nxt;
            full         <= (count_nxt == CNT_FULL);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_AF);
            almost_empty <= (count_nxt <= CNT_AE);
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (s_tick & wr & ~wr_ok) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (s_tick & rd & empty) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/uart_fifo_lvl.md
UART_FIFO_LVL -- requirements
Module: uart_fifo_lvl

Interface
REQ-001 Parameter DATA_SIZE, default 10, word width in bits (>=1).
REQ-002 Parameter SIZE_FIFO, default 16, depth in words; power of two, >=2.
REQ-003 Parameter AF_THRESH, default 14, almost_full asserts when count >= AF_THRESH; range 1..SIZE_FIFO.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH; range 0..SIZE_FIFO-1.
REQ-005 Parameter ADDR_WIDTH, default clog2(SIZE_FIFO), pointer width; derived, not overridden.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 s_tick  input  1  enable; FIFO state (storage, pointers, count, flags) updates only on clk edges with s_tick=1.
REQ-009 w_data  input  DATA_SIZE  write data.
REQ-010 wr  input  1  write request, sampled when s_tick=1.
REQ-011 rd  input  1  read request (pop), sampled when s_tick=1.
REQ-012 err_clr  input  1  clears sticky error flags.
REQ-013 r_data  output  DATA_SIZE  head-of-queue word (show-ahead).
REQ-014 full  output  1  count == SIZE_FIFO.
REQ-015 empty  output  1  count == 0.
REQ-016 almost_full  output  1  count >= AF_THRESH.
REQ-017 almost_empty  output  1  count <= AE_THRESH.
REQ-018 count  output  ADDR_WIDTH+1  current occupancy, 0..SIZE_FIFO.
REQ-019 overflow  output  1  sticky: write rejected since last clear.
REQ-020 underflow  output  1  sticky: read of empty FIFO since last clear.

Function
REQ-021 r_data SHALL combinationally present storage[r_ptr]; valid only while empty=0, undefined-but-stable content otherwise.
REQ-022 Write accepted (wr_ok) when s_tick & wr & (~full | (rd & ~empty)); stores w_data at w_ptr, w_ptr increments modulo SIZE_FIFO.
REQ-023 Read accepted (rd_ok) when s_tick & rd & ~empty; r_ptr increments modulo SIZE_FIFO.
REQ-024 count next = count + wr_ok - rd_ok; no wrap, never exceeds SIZE_FIFO nor drops below 0.
REQ-025 wr & rd while empty: write accepted, read ignored, count +1, underflow event.
REQ-026 wr & rd while full: both accepted, count unchanged, new word lands in slot just freed, no overflow.
REQ-027 wr & rd otherwise: both accepted, count unchanged.
REQ-028 full, empty, almost_full, almost_empty SHALL be registered and consistent with count every cycle (1-cycle latency from request edge).
REQ-029 Pointer wrap from SIZE_FIFO-1 to 0 SHALL preserve FIFO order.
REQ-030 With s_tick=0 requests are ignored entirely; no storage, pointer, count or flag change.

Reset
REQ-031 reset_n=0 SHALL immediately force: pointers 0, count 0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-032 Storage array is not reset; reset mid-operation discards all queued words.

Configuration
REQ-033 Macro UART_FIFO_ERR_FLAGS_EN defined: overflow set on edge with s_tick & wr & ~wr_ok; underflow set on edge with s_tick & rd & empty; err_clr=1 clears both on any clk edge (s_tick irrelevant); set wins over clear in the same cycle.
REQ-034 Macro undefined: overflow and underflow tied to 0, err_clr ignored, no flag registers synthesised; all other behaviour identical.

Verification (SIZE_FIFO=4, DATA_SIZE=10, AF_THRESH=3, AE_THRESH=1, macro defined)
REQ-035 Reset, then write 0x001,0x002,0x003,0x004 -> count 1,2,3,4; almost_empty drops at count 2; almost_full at count 3; full at 4; r_data=0x001 throughout.
REQ-036 Full, wr=1 w_data=0x3FF rd=0 -> count stays 4, overflow=1; then 4 reads return 0x001..0x004, empty=1, 0x3FF never appears.
REQ-037 Full, wr&rd with 0x155 -> count 4, r_data 0x002 next; after 4 more reads last word 0x155; 6 writes/reads wrap pointers with order intact.
REQ-038 Empty, wr&rd with 0x0AA -> count 1, r_data=0x0AA, underflow=1; err_clr=1 one cycle -> overflow=0, underflow=0.
REQ-039 wr=1 with s_tick=0 for 5 cycles -> count 0, empty=1; assert reset_n=0 at count 3 -> count 0, empty=1 asynchronously.
